// File: rtl/vga_sync_ctrl.sv
// vga_sync_ctrl: raster timing controller (hsync/vsync, address enables, pixel/line indices, frame strobe).
// Latency: all outputs are flops that show the new counter position in the cycle right after the tick edge.
// Backpressure: none; the counters advance only on clk edges with i_px_clk=1, and i_sclr has priority.
//
// Ports:
//   clk          system clock
//   i_sclr       synchronous active-high clear (to the last position of the frame)
//   i_px_clk     one-clk-wide pixel tick enable
//   o_hsync      horizontal sync, active low
//   o_vsync      vertical sync, active low
//   o_haddr_enb  horizontal counter in the active phase
//   o_vaddr_enb  vertical counter in the active phase
//   o_hidx       active pixel index, 0 outside the active phase
//   o_vidx       active line index, 0 outside the active phase
//   o_frame_en   one-clk strobe at the start of vertical blanking
module vga_sync_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       i_sclr,
  input  logic       i_px_clk,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_haddr_enb,
  output logic       o_vaddr_enb,
  output logic [9:0] o_hidx,
  output logic [8:0] o_vidx,
  output logic       o_frame_en
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Last count value of each phase.
  localparam logic [9:0] H_ACT_END = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_FP_END  = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] H_SYN_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_END = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_FP_END  = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0] V_SYN_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYN, H_BACK} h_state_t;
  typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYN, V_BACK} v_state_t;

  h_state_t   h_state, h_state_nxt;
  v_state_t   v_state, v_state_nxt;
  logic [9:0] hcnt, hcnt_nxt;
  logic [9:0] vcnt, vcnt_nxt;
  logic       h_wrap;
  logic       v_wrap;
  logic       frame_set;

  assign h_wrap = (hcnt == H_LAST);
  assign v_wrap = (vcnt == V_LAST);

  // Next-state logic: everything holds unless this edge carries a pixel tick.
  always_comb begin
    h_state_nxt = h_state;
    v_state_nxt = v_state;
    hcnt_nxt    = hcnt;
    vcnt_nxt    = vcnt;
    frame_set   = 1'b0;

    if (i_px_clk) begin
      hcnt_nxt = h_wrap ? 10'd0 : hcnt + 10'd1;

      case (h_state)
        H_ACT:   if (hcnt == H_ACT_END) h_state_nxt = H_FRONT;
        H_FRONT: if (hcnt == H_FP_END)  h_state_nxt = H_SYN;
        H_SYN:   if (hcnt == H_SYN_END) h_state_nxt = H_BACK;
        H_BACK:  if (h_wrap)            h_state_nxt = H_ACT;
        default:                        h_state_nxt = H_BACK;
      endcase

      // The vertical side only moves on the line wrap.
      if (h_wrap) begin
        vcnt_nxt = v_wrap ? 10'd0 : vcnt + 10'd1;

        case (v_state)
          V_ACT:   if (vcnt == V_ACT_END) v_state_nxt = V_FRONT;
          V_FRONT: if (vcnt == V_FP_END)  v_state_nxt = V_SYN;
          V_SYN:   if (vcnt == V_SYN_END) v_state_nxt = V_BACK;
          V_BACK:  if (v_wrap)            v_state_nxt = V_ACT;
          default:                        v_state_nxt = V_BACK;
        endcase

        // Last pixel of the last active line: blanking starts on this edge.
        frame_set = (vcnt == V_ACT_END);
      end
    end
  end

  // State registers. Outputs are decoded from the next state so that the
  // registered outputs line up with the registered counters.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      hcnt        <= H_LAST;
      vcnt        <= V_LAST;
      h_state     <= H_BACK;
      v_state     <= V_BACK;
      o_hsync     <= 1'b1;
      o_vsync     <= 1'b1;
      o_haddr_enb <= 1'b0;
      o_vaddr_enb <= 1'b0;
      o_hidx      <= 10'd0;
      o_vidx      <= 9'd0;
      o_frame_en  <= 1'b0;
    end else begin
      hcnt        <= hcnt_nxt;
      vcnt        <= vcnt_nxt;
      h_state     <= h_state_nxt;
      v_state     <= v_state_nxt;
      o_hsync     <= (h_state_nxt != H_SYN);
      o_vsync     <= (v_state_nxt != V_SYN);
      o_haddr_enb <= (h_state_nxt == H_ACT);
      o_vaddr_enb <= (v_state_nxt == V_ACT);
      o_hidx      <= (h_state_nxt == H_ACT) ? hcnt_nxt : 10'd0;
      o_vidx      <= (v_state_nxt == V_ACT) ? vcnt_nxt[8:0] : 9'd0;
      // Strobe is rebuilt every edge, so it self-clears on the next clk.
      o_frame_en  <= frame_set;
    end
  end

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// tb_vga_sync_ctrl: directed bench for vga_sync_ctrl (full-size instance plus a shrunken-timing instance).
// Latency: outputs sampled 1 time unit after each posedge, compared against a table and a position model.
// Backpressure: none; the bench drives i_sclr/i_px_clk directly.
module tb_vga_sync_ctrl;

  logic clk = 1'b0;
  logic i_sclr = 1'b1;
  logic i_px_clk = 1'b1;

  logic       d_hsync, d_vsync, d_haddr_enb, d_vaddr_enb, d_frame_en;
  logic [9:0] d_hidx;
  logic [8:0] d_vidx;
  logic       s_hsync, s_vsync, s_haddr_enb, s_vaddr_enb, s_frame_en;
  logic [9:0] s_hidx;
  logic [8:0] s_vidx;

  always #5 clk = ~clk;

  vga_sync_ctrl dut (
    .clk(clk), .i_sclr(i_sclr), .i_px_clk(i_px_clk),
    .o_hsync(d_hsync), .o_vsync(d_vsync),
    .o_haddr_enb(d_haddr_enb), .o_vaddr_enb(d_vaddr_enb),
    .o_hidx(d_hidx), .o_vidx(d_vidx), .o_frame_en(d_frame_en)
  );

  // Small raster: 16 ticks per line, 13 lines per frame, 208 ticks per frame.
  vga_sync_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_s (
    .clk(clk), .i_sclr(i_sclr), .i_px_clk(i_px_clk),
    .o_hsync(s_hsync), .o_vsync(s_vsync),
    .o_haddr_enb(s_haddr_enb), .o_vaddr_enb(s_vaddr_enb),
    .o_hidx(s_hidx), .o_vidx(s_vidx), .o_frame_en(s_frame_en)
  );

  int p_ha [2] = '{640, 8};
  int p_hf [2] = '{16, 2};
  int p_hs [2] = '{96, 3};
  int p_hb [2] = '{48, 3};
  int p_va [2] = '{480, 6};
  int p_vf [2] = '{10, 2};
  int p_vs [2] = '{2, 2};
  int p_vb [2] = '{33, 3};

  int   mh [2];
  int   mv [2];
  logic mfe [2];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic sclr;
    logic px;
    logic hs;
    logic vs;
    logic he;
    logic ve;
    int   hi;
    int   vi;
    logic fe;
  } vec_t;

  vec_t tbl [13];

  function automatic int htot(input int k);
    return p_ha[k] + p_hf[k] + p_hs[k] + p_hb[k];
  endfunction

  function automatic int vtot(input int k);
    return p_va[k] + p_vf[k] + p_vs[k] + p_vb[k];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic get_act(input int k, output logic [31:0] a_hs, output logic [31:0] a_vs,
                         output logic [31:0] a_he, output logic [31:0] a_ve,
                         output logic [31:0] a_hi, output logic [31:0] a_vi,
                         output logic [31:0] a_fe);
    if (k == 0) begin
      a_hs = 32'(d_hsync);     a_vs = 32'(d_vsync);
      a_he = 32'(d_haddr_enb); a_ve = 32'(d_vaddr_enb);
      a_hi = 32'(d_hidx);      a_vi = 32'(d_vidx);
      a_fe = 32'(d_frame_en);
    end else begin
      a_hs = 32'(s_hsync);     a_vs = 32'(s_vsync);
      a_he = 32'(s_haddr_enb); a_ve = 32'(s_vaddr_enb);
      a_hi = 32'(s_hidx);      a_vi = 32'(s_vidx);
      a_fe = 32'(s_frame_en);
    end
  endtask

  // Position model: advance the expected raster position for both instances.
  task automatic model_step(input logic sclr, input logic px);
    for (int k = 0; k < 2; k++) begin
      mfe[k] = 1'b0;
      if (sclr) begin
        mh[k] = htot(k) - 1;
        mv[k] = vtot(k) - 1;
      end else if (px) begin
        if (mh[k] == htot(k) - 1) begin
          if (mv[k] == p_va[k] - 1) mfe[k] = 1'b1;
          mh[k] = 0;
          mv[k] = (mv[k] == vtot(k) - 1) ? 0 : mv[k] + 1;
        end else begin
          mh[k] = mh[k] + 1;
        end
      end
    end
  endtask

  // Compare every output of both instances against the position model.
  task automatic check_model();
    logic [31:0] a_hs, a_vs, a_he, a_ve, a_hi, a_vi, a_fe;
    for (int k = 0; k < 2; k++) begin
      int   hs_lo = p_ha[k] + p_hf[k];
      int   hs_hi = hs_lo + p_hs[k];
      int   vs_lo = p_va[k] + p_vf[k];
      int   vs_hi = vs_lo + p_vs[k];
      logic e_he  = (mh[k] < p_ha[k]);
      logic e_ve  = (mv[k] < p_va[k]);
      logic e_hs  = !(mh[k] >= hs_lo && mh[k] < hs_hi);
      logic e_vs  = !(mv[k] >= vs_lo && mv[k] < vs_hi);
      int   e_hi  = e_he ? mh[k] : 0;
      int   e_vi  = e_ve ? (mv[k] % 512) : 0;
      get_act(k, a_hs, a_vs, a_he, a_ve, a_hi, a_vi, a_fe);
      chk($sformatf("dut%0d hsync @(%0d,%0d)", k, mh[k], mv[k]), a_hs, 32'(e_hs));
      chk($sformatf("dut%0d vsync @(%0d,%0d)", k, mh[k], mv[k]), a_vs, 32'(e_vs));
      chk($sformatf("dut%0d haddr_enb @(%0d,%0d)", k, mh[k], mv[k]), a_he, 32'(e_he));
      chk($sformatf("dut%0d vaddr_enb @(%0d,%0d)", k, mh[k], mv[k]), a_ve, 32'(e_ve));
      chk($sformatf("dut%0d hidx @(%0d,%0d)", k, mh[k], mv[k]), a_hi, 32'(e_hi));
      chk($sformatf("dut%0d vidx @(%0d,%0d)", k, mh[k], mv[k]), a_vi, 32'(e_vi));
      chk($sformatf("dut%0d frame_en @(%0d,%0d)", k, mh[k], mv[k]), a_fe, 32'(mfe[k]));
    end
  endtask

  task automatic step(input logic sclr, input logic px);
    i_sclr   = sclr;
    i_px_clk = px;
    @(posedge clk);
    #1;
    model_step(sclr, px);
    check_model();
  endtask

  initial begin
    logic [31:0] a_hs, a_vs, a_he, a_ve, a_hi, a_vi, a_fe;
    int   hs_low_cnt;
    int   fe_pulses;
    int   last_fe;
    int   vs_run;
    int   ticks;
    bit   found;

    // sclr px | hs vs he ve hi vi fe
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1, 0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2, 0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3, 0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 0, 1'b0};

    for (int k = 0; k < 2; k++) begin
      mh[k]  = htot(k) - 1;
      mv[k]  = vtot(k) - 1;
      mfe[k] = 1'b0;
    end

    // Table: reset, release, gaps, re-reset; same expectations for both instances.
    for (int i = 0; i < 13; i++) begin
      i_sclr   = tbl[i].sclr;
      i_px_clk = tbl[i].px;
      @(posedge clk);
      #1;
      model_step(tbl[i].sclr, tbl[i].px);
      for (int k = 0; k < 2; k++) begin
        get_act(k, a_hs, a_vs, a_he, a_ve, a_hi, a_vi, a_fe);
        chk($sformatf("vec%0d dut%0d hsync", i, k), a_hs, 32'(tbl[i].hs));
        chk($sformatf("vec%0d dut%0d vsync", i, k), a_vs, 32'(tbl[i].vs));
        chk($sformatf("vec%0d dut%0d haddr_enb", i, k), a_he, 32'(tbl[i].he));
        chk($sformatf("vec%0d dut%0d vaddr_enb", i, k), a_ve, 32'(tbl[i].ve));
        chk($sformatf("vec%0d dut%0d hidx", i, k), a_hi, 32'(tbl[i].hi));
        chk($sformatf("vec%0d dut%0d vidx", i, k), a_vi, 32'(tbl[i].vi));
        chk($sformatf("vec%0d dut%0d frame_en", i, k), a_fe, 32'(tbl[i].fe));
      end
    end

    // Continuous ticks: one full default line, several small frames.
    hs_low_cnt = 0;
    fe_pulses  = 0;
    last_fe    = -1;
    vs_run     = 0;
    for (int i = 0; i < 900; i++) begin
      step(1'b0, 1'b1);
      if (i < 800 && d_hsync == 1'b0) hs_low_cnt++;
      if (s_vsync == 1'b0) begin
        vs_run++;
      end else if (vs_run != 0) begin
        chk("small vsync low run", 32'(vs_run), 32'd32);
        vs_run = 0;
      end
      if (s_frame_en) begin
        if (last_fe >= 0) chk("small frame_en period", 32'(i - last_fe), 32'd208);
        last_fe = i;
        fe_pulses++;
      end
    end
    chk("default hsync low ticks per line", 32'(hs_low_cnt), 32'd96);
    chk("small frame_en pulse count >= 4", 32'(fe_pulses >= 4), 32'd1);

    // Gapped pixel enable, 1-in-4.
    for (int i = 0; i < 2000; i++) step(1'b0, (i % 4) == 0);

    // Mid-frame reset at (5,3) of the small raster.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (mh[1] == 5 && mv[1] == 3) found = 1'b1;
      else step(1'b0, 1'b1);
    end
    chk("reach (5,3) before mid-frame reset", 32'(found), 32'd1);
    step(1'b1, 1'b1);
    chk("mid-frame reset hsync", 32'(s_hsync), 32'd1);
    chk("mid-frame reset haddr_enb", 32'(s_haddr_enb), 32'd0);
    step(1'b0, 1'b1);
    chk("first tick after reset hidx", 32'(s_hidx), 32'd0);
    chk("first tick after reset vaddr_enb", 32'(s_vaddr_enb), 32'd1);
    ticks = 0;
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step(1'b0, 1'b1);
      ticks++;
      if (s_frame_en) found = 1'b1;
    end
    chk("frame_en seen after reset", 32'(found), 32'd1);
    chk("ticks from (0,0) to frame_en", 32'(ticks), 32'd96);

    // Reset on the edge where frame_en would set.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (mh[1] == 15 && mv[1] == 5) found = 1'b1;
      else step(1'b0, 1'b1);
    end
    chk("reach (15,5) before strobe reset", 32'(found), 32'd1);
    step(1'b1, 1'b1);
    chk("reset over strobe frame_en", 32'(s_frame_en), 32'd0);
    chk("reset over strobe vidx", 32'(s_vidx), 32'd0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
